mmio_uart_ctrl: RTL and testbench

Memory-mapped I/O responder for the Riscv151 data-side port. It decodes CPU loads and stores in the 0x8000_0000 region and presents UART status, receive data, transmit data, a cycle counter, an instruction counter and a counter-reset register. It sits between the core's EX/MWB data-memory signals and the on-chip `uart` ready/valid ports. Each direction has a small FIFO so the core can issue back-to-back stores and loads without stalling.

---
 rtl/mmio_uart_ctrl_if.sv | 26 ++
 rtl/mmio_uart_ctrl.sv | 121 ++++++++++++
 tb/tb_mmio_uart_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_ctrl_if.sv
// Data-side MMIO bus plus UART ready/valid links for mmio_uart_ctrl.
// The slave modport is the responder's view; the master modport is the core/UART side.
interface mmio_uart_ctrl_if;
  logic [31:0] addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        inst_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport slave (
    input  addr, re, we, wdata, inst_valid, tx_ready, rx_data, rx_valid,
    output rdata, tx_data, tx_valid, rx_ready
  );

  modport master (
    output addr, re, we, wdata, inst_valid, tx_ready, rx_data, rx_valid,
    input  rdata, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/mmio_uart_ctrl.sv
// MMIO responder in the 0x8000_0000 region: UART status/data with TX and RX FIFOs,
// cycle and retired-instruction counters, and a one-cycle registered load path.
module mmio_uart_ctrl #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] MMIO_BASE  = 4'h8
) (
  input  logic            clk,
  input  logic            rst,
  mmio_uart_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [7:0] OFF_CTRL  = 8'h00;
  localparam logic [7:0] OFF_RX    = 8'h04;
  localparam logic [7:0] OFF_TX    = 8'h08;
  localparam logic [7:0] OFF_CYCLE = 8'h10;
  localparam logic [7:0] OFF_INSTR = 8'h14;
  localparam logic [7:0] OFF_CNT   = 8'h18;

  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic             tx_ovf;
  logic [31:0]      cycle_cnt, instr_cnt;
  logic [31:0]      rd_word_p0;
  logic [31:0]      rdata_p1;

  logic       sel;
  logic [7:0] off;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
  logic       ovf_clr, cnt_clr;

  assign sel      = (bus.addr[31:28] == MMIO_BASE);
  assign off      = bus.addr[7:0];
  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);

  // Fullness is judged from start-of-cycle state, so a same-cycle pop never frees a slot.
  assign tx_push_req = sel && bus.we[0] && (off == OFF_TX);
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_pop      = !tx_empty && bus.tx_ready;
  assign rx_push     = bus.rx_valid && !rx_full;
  assign rx_pop      = sel && bus.re && (off == OFF_RX) && !rx_empty;
  assign ovf_clr     = sel && bus.we[0] && (off == OFF_CTRL) && bus.wdata[2];
  assign cnt_clr     = sel && (off == OFF_CNT) && (|bus.we);

  assign bus.tx_valid = !tx_empty;
  assign bus.tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd];
  assign bus.rx_ready = !rx_full;
  assign bus.rdata    = rdata_p1;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.addr[27:8], bus.wdata[31:8]};

  // Stage p0: read mux over start-of-cycle state.
  always_comb begin
    rd_word_p0 = 32'h0;
    unique case (off)
      OFF_CTRL:  rd_word_p0 = {29'h0, tx_ovf, !rx_empty, !tx_full};
      OFF_RX:    rd_word_p0 = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd]};
      OFF_CYCLE: rd_word_p0 = cycle_cnt;
      OFF_INSTR: rd_word_p0 = instr_cnt;
      default:   rd_word_p0 = 32'h0;
    endcase
  end

  // Stage p1: registered load data, held until the next selected load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_p1 <= 32'h0;
    end else if (bus.re && sel) begin
      rdata_p1 <= rd_word_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= bus.wdata[7:0];
    if (rx_push) rx_mem[rx_wr] <= bus.rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
      tx_ovf <= 1'b0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PTR_W'(1);
      if (tx_pop)  tx_rd <= tx_rd + PTR_W'(1);
      tx_cnt <= tx_cnt + CNT_W'(tx_push) - CNT_W'(tx_pop);
      if (rx_push) rx_wr <= rx_wr + PTR_W'(1);
      if (rx_pop)  rx_rd <= rx_rd + PTR_W'(1);
      rx_cnt <= rx_cnt + CNT_W'(rx_push) - CNT_W'(rx_pop);
      if (tx_push_req && tx_full) tx_ovf <= 1'b1;
      else if (ovf_clr)           tx_ovf <= 1'b0;
    end
  end

  // A counter-reset store swallows that cycle's increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= 32'h0;
      instr_cnt <= 32'h0;
    end else if (cnt_clr) begin
      cycle_cnt <= 32'h0;
      instr_cnt <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      instr_cnt <= instr_cnt + 32'(bus.inst_valid);
    end
  end
endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed bench for mmio_uart_ctrl: a table of bus transactions plus hand-written
// sequences for FIFO ordering, overflow, counters, wrap and asynchronous reset.
module tb_mmio_uart_ctrl;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk;
  logic rst;
  mmio_uart_ctrl_if bus ();

  mmio_uart_ctrl #(.FIFO_DEPTH(4), .MMIO_BASE(4'h8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = be;
    @(negedge clk);
    bus.we    = 4'h0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] r);
    bus.addr = a;
    bus.re   = 1'b1;
    @(negedge clk);
    bus.re   = 1'b0;
    r        = bus.rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    int exp_instr;

    bus.addr = 32'h0; bus.re = 1'b0; bus.we = 4'h0; bus.wdata = 32'h0;
    bus.inst_valid = 1'b0; bus.tx_ready = 1'b0;
    bus.rx_data = 8'h0; bus.rx_valid = 1'b0;
    rst = 1'b0;

    tbl[0] = '{1'b0, BASE + 32'h00, 32'h0,  32'h1};
    tbl[1] = '{1'b1, BASE + 32'h08, 32'h41, 32'h0};
    tbl[2] = '{1'b1, BASE + 32'h08, 32'h42, 32'h0};
    tbl[3] = '{1'b1, BASE + 32'h08, 32'h43, 32'h0};
    tbl[4] = '{1'b1, BASE + 32'h08, 32'h44, 32'h0};
    tbl[5] = '{1'b1, BASE + 32'h08, 32'h45, 32'h0};
    tbl[6] = '{1'b0, BASE + 32'h00, 32'h0,  32'h4};
    tbl[7] = '{1'b0, BASE + 32'h08, 32'h0,  32'h0};
    tbl[8] = '{1'b0, BASE + 32'h0C, 32'h0,  32'h0};
    tbl[9] = '{1'b0, BASE + 32'h04, 32'h0,  32'h0};

    #12;
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    check("rst_rx_ready", {31'h0, bus.rx_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].st) begin
        store(tbl[i].addr, tbl[i].wdata, 4'h1);
      end else begin
        load(tbl[i].addr, r);
        check($sformatf("tbl%0d", i), r, tbl[i].exp);
      end
    end

    check("tx_head_valid", {31'h0, bus.tx_valid}, 32'h1);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tx_order%0d", i), {24'h0, bus.tx_data}, 32'h41 + 32'(i));
      @(negedge clk);
    end
    check("tx_drained", {31'h0, bus.tx_valid}, 32'h0);
    bus.tx_ready = 1'b0;
    store(BASE + 32'h00, 32'h4, 4'h1);
    load(BASE + 32'h00, r);
    check("ovf_clear", r, 32'h1);

    bus.rx_valid = 1'b1; bus.rx_data = 8'h5A;
    @(negedge clk);
    bus.rx_data = 8'h5B;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    load(BASE + 32'h00, r); check("rx_ctrl", r, 32'h3);
    load(BASE + 32'h04, r); check("rx_pop0", r, 32'h5A);
    load(BASE + 32'h04, r); check("rx_pop1", r, 32'h5B);
    load(BASE + 32'h04, r); check("rx_empty_rd", r, 32'h0);
    load(BASE + 32'h00, r); check("rx_ctrl_empty", r, 32'h1);

    bus.rx_valid = 1'b1; bus.rx_data = 8'h99;
    load(BASE + 32'h04, r);
    bus.rx_valid = 1'b0;
    check("rx_push_empty_rd", r, 32'h0);
    load(BASE + 32'h04, r); check("rx_queued", r, 32'h99);

    bus.rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rx_data = 8'h10 + 8'(i);
      @(negedge clk);
    end
    check("rx_full_ready", {31'h0, bus.rx_ready}, 32'h0);
    bus.rx_data = 8'hEE;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load(BASE + 32'h04, r);
      check($sformatf("rx_fill%0d", i), r, 32'h10 + 32'(i));
    end
    load(BASE + 32'h04, r); check("rx_full_drop", r, 32'h0);
    check("rx_ready_back", {31'h0, bus.rx_ready}, 32'h1);

    store(BASE + 32'h18, 32'h0, 4'hF);
    exp_instr = 0;
    for (int i = 0; i < 100; i++) begin
      bus.inst_valid = (i % 2 == 0);
      if (i % 2 == 0) exp_instr++;
      @(negedge clk);
    end
    bus.inst_valid = 1'b0;
    load(BASE + 32'h10, r); check("cycle_100", r, 32'd100);
    load(BASE + 32'h14, r); check("instr_half", r, 32'(exp_instr));
    bus.inst_valid = 1'b1;
    store(BASE + 32'h18, 32'h0, 4'h2);
    load(BASE + 32'h14, r); check("instr_clr", r, 32'h0);
    load(BASE + 32'h10, r); check("cycle_after_clr", r, 32'h1);
    load(BASE + 32'h14, r); check("instr_resume", r, 32'h2);
    bus.inst_valid = 1'b0;

    for (int i = 0; i < 4; i++) store(BASE + 32'h08, 32'h61 + 32'(i), 4'h1);
    bus.tx_ready = 1'b1;
    store(BASE + 32'h08, 32'h65, 4'h1);
    bus.tx_ready = 1'b0;
    load(BASE + 32'h00, r); check("full_pop_push_ctrl", r, 32'h5);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("full_pop_order%0d", i), {24'h0, bus.tx_data}, 32'h62 + 32'(i));
      @(negedge clk);
    end
    check("full_push_dropped", {31'h0, bus.tx_valid}, 32'h0);
    bus.tx_ready = 1'b0;
    store(BASE + 32'h00, 32'h4, 4'h1);
    load(BASE + 32'h00, r); check("ovf_clear2", r, 32'h1);

    force dut.cycle_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    load(BASE + 32'h10, r); check("cycle_fe", r, 32'hFFFF_FFFE);
    load(BASE + 32'h10, r); check("cycle_ff", r, 32'hFFFF_FFFF);
    load(BASE + 32'h10, r); check("cycle_wrap", r, 32'h0);

    check("pre_push_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    store(BASE + 32'h08, 32'h71, 4'h1);
    check("tx_valid_rise", {31'h0, bus.tx_valid}, 32'h1);
    store(BASE + 32'h08, 32'h72, 4'h1);
    store(BASE + 32'h08, 32'h73, 4'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("async_tx_data", {24'h0, bus.tx_data}, 32'h0);
    check("async_rdata", bus.rdata, 32'h0);
    check("async_rx_ready", {31'h0, bus.rx_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    load(BASE + 32'h10, r); check("cycle_after_rst", r, 32'h1);
    load(BASE + 32'h00, r); check("ctrl_after_rst", r, 32'h1);
    check("tx_empty_after_rst", {31'h0, bus.tx_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
